// File: rtl/regfile_bus.sv
// regfile_bus: datapath register bank with NREG general-purpose registers
// (main/LHS/RHS buses) and NADDR address registers (addr/xfer buses).
// A small byte sequencer moves a wide address register over the narrow
// main bus in either direction, and a sticky flag records bus conflicts.
module regfile_bus #(
    parameter int WIDTH_MAIN = 8,
    parameter int WIDTH_AX   = 16,
    parameter int NREG       = 4,
    parameter int NADDR      = 5,
    localparam int GI        = (NREG  > 1) ? $clog2(NREG)  : 1,
    localparam int AI        = (NADDR > 1) ? $clog2(NADDR) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_MAIN-1:0] main_in,
    input  logic                  gp_load,
    input  logic [GI-1:0]         gp_load_idx,
    input  logic                  gp_assert,
    input  logic [GI-1:0]         gp_assert_idx,
    input  logic                  lhs_assert,
    input  logic [GI-1:0]         lhs_idx,
    input  logic                  rhs_assert,
    input  logic [GI-1:0]         rhs_idx,
    input  logic [WIDTH_AX-1:0]   xfer_in,
    input  logic                  ar_load,
    input  logic [AI-1:0]         ar_load_idx,
    input  logic                  ar_assert_xfer,
    input  logic [AI-1:0]         ar_xfer_idx,
    input  logic                  ar_assert_addr,
    input  logic [AI-1:0]         ar_addr_idx,
    input  logic                  ar_inc,
    input  logic                  ar_dec,
    input  logic [AI-1:0]         ar_step_idx,
    input  logic                  wide_load,
    input  logic                  wide_store,
    input  logic [AI-1:0]         wide_idx,
    output logic [WIDTH_MAIN-1:0] main_out,
    output logic                  main_en,
    output logic [WIDTH_MAIN-1:0] lhs_out,
    output logic                  lhs_en,
    output logic [WIDTH_MAIN-1:0] rhs_out,
    output logic                  rhs_en,
    output logic [WIDTH_AX-1:0]   addr_out,
    output logic                  addr_en,
    output logic [WIDTH_AX-1:0]   xfer_out,
    output logic                  xfer_en,
    output logic                  busy,
    output logic                  conflict
);

    localparam int BYTES = WIDTH_AX / WIDTH_MAIN;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STORE
    } state_t;

    // Register values exposed as flat arrays for the read muxes.
    logic [WIDTH_MAIN-1:0] gp_val [NREG];
    logic [WIDTH_AX-1:0]   ar_val [NADDR];

    // Sequencer state. One buffer serves as the load shadow and the store snapshot.
    state_t                state_q, state_d;
    logic [CW-1:0]         k_q, k_d;
    logic [AI-1:0]         widx_q, widx_d;
    logic [WIDTH_AX-1:0]   shadow_q, shadow_d;

    logic                  wide_commit;
    logic [AI-1:0]         commit_idx;
    logic [WIDTH_AX-1:0]   commit_val;
    logic [WIDTH_AX-1:0]   wide_src;

    logic [WIDTH_MAIN-1:0] gp_main_rd, lhs_rd, rhs_rd, store_byte;
    logic [WIDTH_AX-1:0]   addr_rd, xfer_rd;

    logic                  conflict_q, conflict_set;

    // ------------------------------------------------------------------
    // General-purpose registers: single write port from main_in.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREG; gi++) begin : g_gp
        logic [WIDTH_MAIN-1:0] gp_q;

        // Load the selected GP register from the main bus.
        always_ff @(posedge clk) begin
            if (reset) begin
                gp_q <= '0;
            end else if (gp_load && gp_load_idx == GI'(gi)) begin
                gp_q <= main_in;
            end
        end

        assign gp_val[gi] = gp_q;
    end

    // ------------------------------------------------------------------
    // Address registers: wide commit beats ar_load beats inc/dec.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NADDR; gi++) begin : g_ar
        logic [WIDTH_AX-1:0] ar_q, ar_d;

        // Next value, lowest priority applied first so later writes override.
        always_comb begin
            ar_d = ar_q;
            if (ar_step_idx == AI'(gi) && (ar_inc ^ ar_dec)) begin
                ar_d = ar_inc ? (ar_q + 1'b1) : (ar_q - 1'b1);
            end
            if (ar_load && ar_load_idx == AI'(gi)) begin
                ar_d = xfer_in;
            end
            if (wide_commit && commit_idx == AI'(gi)) begin
                ar_d = commit_val;
            end
        end

        // Address register state.
        always_ff @(posedge clk) begin
            if (reset) begin
                ar_q <= '0;
            end else begin
                ar_q <= ar_d;
            end
        end

        assign ar_val[gi] = ar_q;
    end

    // ------------------------------------------------------------------
    // Read muxes. Out-of-range indices read as zero.
    // ------------------------------------------------------------------
    // Select GP values for the main, LHS and RHS ports.
    always_comb begin
        gp_main_rd = '0;
        lhs_rd     = '0;
        rhs_rd     = '0;
        for (int i = 0; i < NREG; i++) begin
            if (gp_assert_idx == GI'(i)) gp_main_rd = gp_val[i];
            if (lhs_idx == GI'(i))       lhs_rd     = gp_val[i];
            if (rhs_idx == GI'(i))       rhs_rd     = gp_val[i];
        end
    end

    // Select AR values for the addr and xfer ports and the store snapshot.
    always_comb begin
        addr_rd  = '0;
        xfer_rd  = '0;
        wide_src = '0;
        for (int i = 0; i < NADDR; i++) begin
            if (ar_addr_idx == AI'(i)) addr_rd  = ar_val[i];
            if (ar_xfer_idx == AI'(i)) xfer_rd  = ar_val[i];
            if (wide_idx == AI'(i))    wide_src = ar_val[i];
        end
    end

    // ------------------------------------------------------------------
    // Byte sequencer.
    // ------------------------------------------------------------------
    // Sequencer state registers; reset abandons any partial transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            widx_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            widx_q   <= widx_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state logic. Load has priority over store; starts are only
    // accepted in IDLE. The final load byte is merged combinationally so
    // the whole word reaches the AR on the same edge.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        widx_d      = widx_q;
        shadow_d    = shadow_q;
        wide_commit = 1'b0;
        commit_idx  = widx_q;
        commit_val  = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (wide_load) begin
                    shadow_d                   = '0;
                    shadow_d[WIDTH_MAIN-1:0]   = main_in;
                    widx_d                     = wide_idx;
                    if (BYTES == 1) begin
                        wide_commit = 1'b1;
                        commit_idx  = wide_idx;
                        commit_val  = shadow_d;
                    end else begin
                        state_d = S_LOAD;
                        k_d     = CW'(1);
                    end
                end else if (wide_store) begin
                    shadow_d = wide_src;
                    widx_d   = wide_idx;
                    state_d  = S_STORE;
                    k_d      = '0;
                end
            end
            S_LOAD: begin
                shadow_d[k_q*WIDTH_MAIN +: WIDTH_MAIN] = main_in;
                if (k_q == K_LAST) begin
                    wide_commit = 1'b1;
                    commit_val  = shadow_d;
                    state_d     = S_IDLE;
                    k_d         = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_STORE: begin
                if (k_q == K_LAST) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
    end

    assign store_byte = shadow_q[k_q*WIDTH_MAIN +: WIDTH_MAIN];
    assign busy       = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Conflict detection: two drivers on main, or xfer read/write clash.
    // ------------------------------------------------------------------
    assign conflict_set = (gp_assert && state_q == S_STORE) ||
                          (ar_assert_xfer && ar_load && ar_xfer_idx == ar_load_idx);

    // Sticky conflict flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= 1'b0;
        end else if (conflict_set) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict = conflict_q;

    // ------------------------------------------------------------------
    // Bus outputs. The sequencer owns main while storing.
    // ------------------------------------------------------------------
    // Main bus driver selection.
    always_comb begin
        main_out = '0;
        main_en  = 1'b0;
        if (state_q == S_STORE) begin
            main_out = store_byte;
            main_en  = 1'b1;
        end else if (gp_assert) begin
            main_out = gp_main_rd;
            main_en  = 1'b1;
        end
    end

    assign lhs_out  = lhs_assert     ? lhs_rd  : '0;
    assign lhs_en   = lhs_assert;
    assign rhs_out  = rhs_assert     ? rhs_rd  : '0;
    assign rhs_en   = rhs_assert;
    assign addr_out = ar_assert_addr ? addr_rd : '0;
    assign addr_en  = ar_assert_addr;
    assign xfer_out = ar_assert_xfer ? xfer_rd : '0;
    assign xfer_en  = ar_assert_xfer;

endmodule
